game_board: RTL and testbench
=============================

GAME_BOARD -- requirements
Module: game_board

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port cursor  input  9  one-hot selected cell from the cursor controller; bit i = cell i, row-major, bit 0 top-left.
REQ-004 SHALL have port write  input  1  raw level place request (centre button), synchronous to clk.
REQ-005 SHALL have port newGame  input  1  level; clears the board and restarts play.
REQ-006 SHALL have port boardX  output  9  cells holding X marks.
REQ-007 SHALL have port boardO  output  9  cells holding O marks.
REQ-008 SHALL have port turn  output  1  player to move, 0=X, 1=O.
REQ-009 SHALL have port winner  output  2  00=none, 01=X, 10=O, 11=draw.
REQ-010 SHALL have port gameOver  output  1  high in DONE state.
REQ-011 SHALL have port reject  output  1  one-cycle pulse on a refused placement.
REQ-012 SHALL have port winLine  output  8  winning lines: bits 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.

Function
REQ-013 SHALL register write into writeQ each cycle; place request = write & ~writeQ (rising edge only), giving one placement per press regardless of hold length.
REQ-014 SHALL implement FSM states PLAY, CHECK and DONE.
REQ-015 In PLAY, a place request with cursor one-hot and selected cell empty in boardX|boardO SHALL set that bit in boardX (turn=0) or boardO (turn=1) on the same edge, then enter CHECK.
REQ-016 A place request with cursor not one-hot (zero or multiple bits), or an occupied cell, SHALL leave board and turn unchanged and pulse reject high for exactly one cycle.
REQ-017 In CHECK, the block SHALL evaluate all 8 lines for the mover's marks, then take one of these transitions:
  - win: set winner to the mover and go to DONE;
  - board full (boardX|boardO = 9'h1FF) with no win: set winner=11 and go to DONE;
  - otherwise: toggle turn and return to PLAY.
REQ-018 Latency SHALL be: press edge sampled at cycle N -> board bit visible at N+1 -> winner/gameOver/turn updated at N+2.
REQ-019 Place requests arriving in CHECK SHALL be ignored silently, with no reject pulse.
REQ-020 In DONE, place requests SHALL pulse reject and leave the board unchanged; DONE holds until newGame or reset.
REQ-021 A win on the ninth mark SHALL report the mover as winner, never draw.
REQ-022 newGame high at a clock edge in any state SHALL clear boardX, boardO, winner, winLine and turn, and enter PLAY; newGame takes priority over a simultaneous place request.
REQ-023 An edge on write held across newGame SHALL NOT place a mark, because writeQ keeps updating.
REQ-024 reject SHALL never be high for two consecutive cycles from a single press.

Reset
REQ-025 While resetN is low, all registers SHALL clear immediately, independent of clk: boardX=0, boardO=0, turn=0, winner=00, gameOver=0, reject=0, winLine=0, writeQ=0, state=PLAY.
REQ-026 Reset deassertion SHALL take effect synchronously to the next rising clk edge, and play resumes from an empty board.
REQ-027 Reset asserted during CHECK SHALL abort the evaluation with no residual winner value.

Configuration
REQ-028 Macro GAME_BOARD_WINLINE_EN:
  - defined: winLine SHALL be registered in CHECK alongside winner, with all lines completed by the winning move set (more than one bit allowed), held through DONE, and cleared on newGame/reset.
  - undefined: winLine SHALL be constant 0 and the line-mask register omitted; winner behaviour is identical in both builds.

Verification
REQ-029 After reset, press centre with cursor=9'h010 -> boardX=9'h010 at N+1, turn=1 at N+2, winner=00.
REQ-030 Play X:0,O:3,X:1,O:4,X:2 -> winner=01, gameOver=1, winLine=8'h01 (macro defined) or 8'h00 (undefined); a further press -> reject pulse, board unchanged.
REQ-031 Press on an occupied cell, or with cursor=9'h003 -> one-cycle reject, boardX/boardO/turn unchanged.
REQ-032 Fill the board with the sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 -> winner=11 on the last CHECK.
REQ-033 Hold write high for 50 cycles -> exactly one mark placed.
REQ-034 Assert resetN low mid-game between clock edges -> all outputs zero before the next edge; newGame and press in the same cycle -> empty board, turn=0.

Source files
------------

// File: rtl/game_board.sv
// Tic-tac-toe board: edge-detected placement, CHECK cycle resolves win/draw/turn; win/draw is reported two cycles after the press edge.
// No backpressure; refused presses pulse reject. Optional winning-line mask via GAME_BOARD_WINLINE_EN.
module game_board (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] cursor,
  input  logic       write,
  input  logic       newGame,
  output logic [8:0] boardX,
  output logic [8:0] boardO,
  output logic       turn,
  output logic [1:0] winner,
  output logic       gameOver,
  output logic       reject,
  output logic [7:0] winLine
);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  state_t     state;
  logic       writeQ;
  logic       place_req;
  logic       cursor_ok;
  logic       cell_free;
  logic [8:0] mover;
  logic [7:0] lines;
  logic       has_win;
  logic       full;

  function automatic logic [7:0] lines_of(input logic [8:0] m);
    lines_of[0] = m[0] & m[1] & m[2];
    lines_of[1] = m[3] & m[4] & m[5];
    lines_of[2] = m[6] & m[7] & m[8];
    lines_of[3] = m[0] & m[3] & m[6];
    lines_of[4] = m[1] & m[4] & m[7];
    lines_of[5] = m[2] & m[5] & m[8];
    lines_of[6] = m[0] & m[4] & m[8];
    lines_of[7] = m[2] & m[4] & m[6];
  endfunction

  assign place_req = write & ~writeQ;
  assign cursor_ok = (cursor != 9'd0) && ((cursor & (cursor - 9'd1)) == 9'd0);
  assign cell_free = (cursor & (boardX | boardO)) == 9'd0;
  assign mover     = turn ? boardO : boardX;
  assign lines     = lines_of(mover);
  assign has_win   = |lines;
  assign full      = &(boardX | boardO);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= PLAY;
      writeQ   <= 1'b0;
      boardX   <= 9'd0;
      boardO   <= 9'd0;
      turn     <= 1'b0;
      winner   <= 2'b00;
      gameOver <= 1'b0;
      reject   <= 1'b0;
    end else begin
      // writeQ tracks write even across newGame so a held button cannot place afterwards
      writeQ <= write;
      reject <= 1'b0;
      if (newGame) begin
        state    <= PLAY;
        boardX   <= 9'd0;
        boardO   <= 9'd0;
        turn     <= 1'b0;
        winner   <= 2'b00;
        gameOver <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (place_req) begin
              if (cursor_ok && cell_free) begin
                if (turn) boardO <= boardO | cursor;
                else      boardX <= boardX | cursor;
                state <= CHECK;
              end else begin
                reject <= 1'b1;
              end
            end
          end
          CHECK: begin
            // a win on the last free cell is still a win, so test it before fullness
            if (has_win) begin
              winner   <= turn ? 2'b10 : 2'b01;
              gameOver <= 1'b1;
              state    <= DONE;
            end else if (full) begin
              winner   <= 2'b11;
              gameOver <= 1'b1;
              state    <= DONE;
            end else begin
              turn  <= ~turn;
              state <= PLAY;
            end
          end
          DONE: begin
            if (place_req) reject <= 1'b1;
          end
          default: state <= PLAY;
        endcase
      end
    end
  end

`ifdef GAME_BOARD_WINLINE_EN
  logic [7:0] win_line;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      win_line <= 8'd0;
    end else if (newGame) begin
      win_line <= 8'd0;
    end else if (state == CHECK && has_win) begin
      win_line <= lines;
    end
  end

  assign winLine = win_line;
`else
  assign winLine = 8'd0;
`endif

endmodule

// File: tb/tb_game_board.sv
// Bench for game_board: table of presses replayed against a board model, plus hold/reset/newGame corner sequences.
module tb_game_board;

  logic       clk;
  logic       resetN;
  logic [8:0] cursor;
  logic       write;
  logic       newGame;
  logic [8:0] boardX;
  logic [8:0] boardO;
  logic       turn;
  logic [1:0] winner;
  logic       gameOver;
  logic       reject;
  logic [7:0] winLine;

  game_board dut (
    .clk(clk), .resetN(resetN), .cursor(cursor), .write(write), .newGame(newGame),
    .boardX(boardX), .boardO(boardO), .turn(turn), .winner(winner),
    .gameOver(gameOver), .reject(reject), .winLine(winLine)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] bx;
    logic [8:0] bo;
    logic       trn;
    logic [1:0] win;
    logic       over;
    logic       rej;
    logic [7:0] wl;
  } exp_t;

  typedef struct {
    logic       ng;
    logic [8:0] c;
    logic       rej;
    logic [1:0] win;
    logic [7:0] wl;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[30];

  int checks = 0;
  int errors = 0;

  logic [8:0] m_x, m_o;
  logic       m_turn, m_done;
  logic [1:0] m_win;
  logic [7:0] m_wl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " boardX"}, 32'(boardX), 32'(e.bx));
    chk({tag, " boardO"}, 32'(boardO), 32'(e.bo));
    chk({tag, " turn"}, 32'(turn), 32'(e.trn));
    chk({tag, " winner"}, 32'(winner), 32'(e.win));
    chk({tag, " gameOver"}, 32'(gameOver), 32'(e.over));
    chk({tag, " reject"}, 32'(reject), 32'(e.rej));
    chk({tag, " winLine"}, 32'(winLine), 32'(e.wl));
  endtask

  task automatic model_clear();
    m_x = 9'd0; m_o = 9'd0; m_turn = 1'b0; m_done = 1'b0; m_win = 2'b00; m_wl = 8'd0;
  endtask

  task automatic new_game(input string tag);
    @(negedge clk);
    newGame = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newGame = 1'b0;
    model_clear();
    sb.push_back('{m_x, m_o, m_turn, m_win, m_done, 1'b0, m_wl});
    cmp_pop({tag, " newGame"});
  endtask

  // One press: placement edge, then the CHECK edge. Board comes from the model, outcome from the table.
  task automatic do_press(input string tag, input logic [8:0] c, input logic erej,
                          input logic [1:0] ewin, input logic [7:0] ewl);
    logic legal;
    logic [7:0] wl_exp;
`ifdef GAME_BOARD_WINLINE_EN
    wl_exp = ewl;
`else
    wl_exp = 8'd0;
`endif
    legal = !m_done && ($countones(c) == 1) && ((c & (m_x | m_o)) == 9'd0);
    if (legal) begin
      if (m_turn) m_o = m_o | c;
      else        m_x = m_x | c;
    end
    sb.push_back('{m_x, m_o, m_turn, m_win, m_done, erej, m_wl});
    if (legal) begin
      m_win  = ewin;
      m_done = (ewin != 2'b00);
      m_wl   = wl_exp;
      if (!m_done) m_turn = ~m_turn;
    end
    sb.push_back('{m_x, m_o, m_turn, ewin, m_done, 1'b0, wl_exp});
    cursor = c;
    write  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp_pop({tag, " place"});
    write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp_pop({tag, " check"});
  endtask

  initial begin
    int rej_cnt;
    resetN  = 1'b0;
    cursor  = 9'd0;
    write   = 1'b0;
    newGame = 1'b0;
    model_clear();

    tbl[0]  = '{1'b1, 9'h010, 1'b0, 2'b00, 8'h00};
    tbl[1]  = '{1'b1, 9'h001, 1'b0, 2'b00, 8'h00};
    tbl[2]  = '{1'b0, 9'h008, 1'b0, 2'b00, 8'h00};
    tbl[3]  = '{1'b0, 9'h002, 1'b0, 2'b00, 8'h00};
    tbl[4]  = '{1'b0, 9'h010, 1'b0, 2'b00, 8'h00};
    tbl[5]  = '{1'b0, 9'h004, 1'b0, 2'b01, 8'h01};
    tbl[6]  = '{1'b0, 9'h100, 1'b1, 2'b01, 8'h01};
    tbl[7]  = '{1'b1, 9'h001, 1'b0, 2'b00, 8'h00};
    tbl[8]  = '{1'b0, 9'h001, 1'b1, 2'b00, 8'h00};
    tbl[9]  = '{1'b0, 9'h003, 1'b1, 2'b00, 8'h00};
    tbl[10] = '{1'b0, 9'h000, 1'b1, 2'b00, 8'h00};
    tbl[11] = '{1'b0, 9'h002, 1'b0, 2'b00, 8'h00};
    tbl[12] = '{1'b1, 9'h001, 1'b0, 2'b00, 8'h00};
    tbl[13] = '{1'b0, 9'h002, 1'b0, 2'b00, 8'h00};
    tbl[14] = '{1'b0, 9'h004, 1'b0, 2'b00, 8'h00};
    tbl[15] = '{1'b0, 9'h010, 1'b0, 2'b00, 8'h00};
    tbl[16] = '{1'b0, 9'h008, 1'b0, 2'b00, 8'h00};
    tbl[17] = '{1'b0, 9'h020, 1'b0, 2'b00, 8'h00};
    tbl[18] = '{1'b0, 9'h080, 1'b0, 2'b00, 8'h00};
    tbl[19] = '{1'b0, 9'h040, 1'b0, 2'b00, 8'h00};
    tbl[20] = '{1'b0, 9'h100, 1'b0, 2'b11, 8'h00};
    tbl[21] = '{1'b1, 9'h002, 1'b0, 2'b00, 8'h00};
    tbl[22] = '{1'b0, 9'h004, 1'b0, 2'b00, 8'h00};
    tbl[23] = '{1'b0, 9'h020, 1'b0, 2'b00, 8'h00};
    tbl[24] = '{1'b0, 9'h008, 1'b0, 2'b00, 8'h00};
    tbl[25] = '{1'b0, 9'h001, 1'b0, 2'b00, 8'h00};
    tbl[26] = '{1'b0, 9'h040, 1'b0, 2'b00, 8'h00};
    tbl[27] = '{1'b0, 9'h010, 1'b0, 2'b00, 8'h00};
    tbl[28] = '{1'b0, 9'h080, 1'b0, 2'b00, 8'h00};
    tbl[29] = '{1'b0, 9'h100, 1'b0, 2'b01, 8'h40};

    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back('{9'd0, 9'd0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0});
    cmp_pop("reset");
    resetN = 1'b1;

    for (int i = 0; i < 30; i++) begin
      if (tbl[i].ng) new_game($sformatf("v%0d", i));
      do_press($sformatf("v%0d", i), tbl[i].c, tbl[i].rej, tbl[i].win, tbl[i].wl);
    end

    // Long hold places one mark only and never rejects.
    new_game("hold");
    cursor = 9'h001;
    write  = 1'b1;
    rej_cnt = 0;
    repeat (50) begin
      @(posedge clk);
      @(negedge clk);
      if (reject) rej_cnt++;
    end
    write = 1'b0;
    chk("hold boardX", 32'(boardX), 32'h001);
    chk("hold boardO", 32'(boardO), 32'h000);
    chk("hold turn", 32'(turn), 32'd1);
    chk("hold reject count", 32'(rej_cnt), 32'd0);

    // newGame and a press edge together: board clears, and the still-held write places nothing.
    @(negedge clk);
    newGame = 1'b1;
    write   = 1'b1;
    cursor  = 9'h010;
    @(posedge clk);
    @(negedge clk);
    newGame = 1'b0;
    chk("ng+press boardX", 32'(boardX), 32'h000);
    chk("ng+press turn", 32'(turn), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("held-across-ng boardX", 32'(boardX | boardO), 32'h000);
    chk("held-across-ng reject", 32'(reject), 32'd0);
    write = 1'b0;
    model_clear();

    // Reset asserted between edges while the winning move sits in CHECK.
    new_game("rst");
    do_press("rst a", 9'h001, 1'b0, 2'b00, 8'h00);
    do_press("rst b", 9'h008, 1'b0, 2'b00, 8'h00);
    do_press("rst c", 9'h002, 1'b0, 2'b00, 8'h00);
    do_press("rst d", 9'h010, 1'b0, 2'b00, 8'h00);
    cursor = 9'h004;
    write  = 1'b1;
    @(posedge clk);
    #2;
    chk("rst pre boardX", 32'(boardX), 32'h007);
    resetN = 1'b0;
    #1;
    chk("rst async boardX", 32'(boardX), 32'h000);
    chk("rst async boardO", 32'(boardO), 32'h000);
    chk("rst async turn", 32'(turn), 32'd0);
    chk("rst async winner", 32'(winner), 32'd0);
    chk("rst async gameOver", 32'(gameOver), 32'd0);
    chk("rst async winLine", 32'(winLine), 32'd0);
    write = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    sb.push_back('{9'd0, 9'd0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0});
    cmp_pop("rst after");
    do_press("rst resume", 9'h010, 1'b0, 2'b00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
